// File: rtl/dpa_operand_loader.sv
// Operand loader for the DPA adder: assembles two N-bit operands from W-bit beats.
// Optional synchronous abort port 'flush' is built only with DPA_LOADER_FLUSH_EN defined.
module dpa_operand_loader #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef DPA_LOADER_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_ctrl,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         cin,
    output logic         signed_en
);

    localparam int BEATS = N / W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_cin;
    logic          r_signed_en;

    logic w_accept;
    logic w_last;
    logic w_flush;

`ifdef DPA_LOADER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign in_ready  = (r_state != HOLD);
    assign op_valid  = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == LAST_IDX);

    assign a         = r_a;
    assign b         = r_b;
    assign cin       = r_cin;
    assign signed_en = r_signed_en;

    // Flush outranks both beat acceptance and the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
            r_cnt   <= '0;
        end else if (w_flush) begin
            r_state <= LOAD_A;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= LOAD_B;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (op_ready) begin
                        r_state <= LOAD_A;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Operands keep stale chunks after handoff; only accepted beats overwrite them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_signed_en <= 1'b0;
        end else if (w_accept && !w_flush) begin
            if (r_state == LOAD_A) begin
                r_a[r_cnt*W +: W] <= in_data;
                if (r_cnt == '0) begin
                    r_signed_en <= in_ctrl[1];
                    r_cin       <= in_ctrl[0];
                end
            end else if (r_state == LOAD_B) begin
                r_b[r_cnt*W +: W] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_dpa_operand_loader.sv
// Directed self-checking bench for dpa_operand_loader (N=64, W=16, 8 beats per operation).
// Define DPA_LOADER_FLUSH_EN to also exercise the flush port.
module tb_dpa_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_ctrl;
    logic        op_valid;
    logic        op_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        signed_en;
`ifdef DPA_LOADER_FLUSH_EN
    logic        flush;
`endif

    int nCompared;
    int nMismatched;

    dpa_operand_loader #(.N(64), .W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DPA_LOADER_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .signed_en (signed_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat; returns 1 time unit after the edge that accepts it.
    task automatic sendBeat(input logic [15:0] data, input logic [1:0] ctrl);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_ctrl  = ctrl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic loadOp(input logic [127:0] chunks, input logic [1:0] ctrl0,
                          input logic [1:0] ctrlRest, input int gap);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (gap) @(posedge clk);
            checkVal("no_early_op_valid", {63'd0, op_valid}, 64'd0);
            sendBeat(chunks[k*16 +: 16], (k == 0) ? ctrl0 : ctrlRest);
        end
        checkVal("op_valid_after_last", {63'd0, op_valid}, 64'd1);
        checkVal("in_ready_in_hold", {63'd0, in_ready}, 64'd0);
    endtask

    task automatic consumeOp(input logic junkValid);
        @(negedge clk);
        op_ready = 1'b1;
        in_valid = junkValid;
        in_data  = 16'hBEEF;
        in_ctrl  = 2'b11;
        @(posedge clk);
        #1;
        op_ready = 1'b0;
        in_valid = 1'b0;
        checkVal("op_valid_after_handoff", {63'd0, op_valid}, 64'd0);
        checkVal("in_ready_after_handoff", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 16'h0;
        in_ctrl     = 2'b00;
        op_ready    = 1'b0;
`ifdef DPA_LOADER_FLUSH_EN
        flush       = 1'b0;
`endif

        #3;
        checkVal("reset_a", a, 64'd0);
        checkVal("reset_b", b, 64'd0);
        checkVal("reset_cin", {63'd0, cin}, 64'd0);
        checkVal("reset_signed_en", {63'd0, signed_en}, 64'd0);
        checkVal("reset_op_valid", {63'd0, op_valid}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        $display("[TB] back-to-back load");
        loadOp({64'h0000_0000_0000_0001, 64'h4444_3333_2222_1111}, 2'b01, 2'b01, 0);
        checkVal("b2b_a", a, 64'h4444_3333_2222_1111);
        checkVal("b2b_b", b, 64'h0000_0000_0000_0001);
        checkVal("b2b_cin", {63'd0, cin}, 64'd1);
        checkVal("b2b_signed_en", {63'd0, signed_en}, 64'd0);

        $display("[TB] backpressure with junk beats offered in HOLD");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'hDEAD;
            @(posedge clk);
            #1;
            checkVal("bp_in_ready", {63'd0, in_ready}, 64'd0);
            checkVal("bp_op_valid", {63'd0, op_valid}, 64'd1);
            checkVal("bp_a_stable", a, 64'h4444_3333_2222_1111);
            checkVal("bp_b_stable", b, 64'h0000_0000_0000_0001);
        end
        in_valid = 1'b0;
        consumeOp(1'b1);
        checkVal("a_retained_after_handoff", a, 64'h4444_3333_2222_1111);
        checkVal("cin_retained_after_handoff", {63'd0, cin}, 64'd1);

        $display("[TB] gapped input");
        loadOp({64'h0000_0000_0000_0001, 64'h4444_3333_2222_1111}, 2'b01, 2'b01, 2);
        checkVal("gap_a", a, 64'h4444_3333_2222_1111);
        checkVal("gap_b", b, 64'h0000_0000_0000_0001);
        checkVal("gap_cin", {63'd0, cin}, 64'd1);
        consumeOp(1'b0);

        $display("[TB] control sampled on first beat only");
        loadOp({64'hFFFF_0000_1234_5678, 64'h0123_4567_89AB_CDEF}, 2'b10, 2'b01, 0);
        checkVal("ctrl_a", a, 64'h0123_4567_89AB_CDEF);
        checkVal("ctrl_b", b, 64'hFFFF_0000_1234_5678);
        checkVal("ctrl_signed_en", {63'd0, signed_en}, 64'd1);
        checkVal("ctrl_cin", {63'd0, cin}, 64'd0);
        consumeOp(1'b0);

        $display("[TB] reset mid-load");
        for (int k = 0; k < 5; k++) sendBeat(16'h7000 + 16'(k), 2'b11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("midrst_a", a, 64'd0);
        checkVal("midrst_b", b, 64'd0);
        checkVal("midrst_op_valid", {63'd0, op_valid}, 64'd0);
        checkVal("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        loadOp({64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC}, 2'b00, 2'b11, 0);
        checkVal("postrst_a", a, 64'h9999_AAAA_BBBB_CCCC);
        checkVal("postrst_b", b, 64'h5555_6666_7777_8888);
        checkVal("postrst_cin", {63'd0, cin}, 64'd0);
        checkVal("postrst_signed_en", {63'd0, signed_en}, 64'd0);
        consumeOp(1'b0);

`ifdef DPA_LOADER_FLUSH_EN
        $display("[TB] flush after six beats");
        sendBeat(16'h0A01, 2'b00);
        sendBeat(16'h0A02, 2'b00);
        sendBeat(16'h0A03, 2'b00);
        sendBeat(16'h0A04, 2'b00);
        sendBeat(16'h0B01, 2'b00);
        sendBeat(16'h0B02, 2'b00);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0B03;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkVal("flush_op_valid", {63'd0, op_valid}, 64'd0);
        checkVal("flush_in_ready", {63'd0, in_ready}, 64'd1);
        checkVal("flush_a_kept", a, 64'h0A04_0A03_0A02_0A01);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkVal("flush_beats_ignored", a, 64'h0A04_0A03_0A02_0A01);
        loadOp({64'hFEDC_BA98_7654_3210, 64'h1357_9BDF_2468_ACE0}, 2'b11, 2'b00, 0);
        checkVal("postflush_a", a, 64'h1357_9BDF_2468_ACE0);
        checkVal("postflush_b", b, 64'hFEDC_BA98_7654_3210);
        checkVal("postflush_cin", {63'd0, cin}, 64'd1);
        checkVal("postflush_signed_en", {63'd0, signed_en}, 64'd1);
        @(negedge clk);
        flush    = 1'b1;
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        op_ready = 1'b0;
        checkVal("flush_hs_op_valid", {63'd0, op_valid}, 64'd0);
        checkVal("flush_hs_in_ready", {63'd0, in_ready}, 64'd1);
        checkVal("flush_hs_a_kept", a, 64'h1357_9BDF_2468_ACE0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
